// File: rtl/snn_cfg_pkg.sv
// snn_cfg_pkg
//   Shared definitions for the SNN configuration loader: the loader FSM
//   state encoding, the default frame start marker and the byte offsets of
//   each field inside the configuration image for the default bus geometry
//   (640-bit weights, 320-bit delays).
package snn_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CSUM  = 2'd2,
        CHECK = 2'd3
    } cfg_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Default geometry the offsets below are expressed against.
    localparam int W_BITS_DEFAULT = 640;
    localparam int D_BITS_DEFAULT = 320;

    // Byte offsets inside {refractory_period, decay, threshold, delays, weights}.
    localparam int WEIGHTS_OFF = 0;
    localparam int DELAYS_OFF  = 80;
    localparam int THR_OFF     = 120;
    localparam int DECAY_OFF   = 121;
    localparam int REFR_OFF    = 122;

endpackage

// File: rtl/snn_config_loader.sv
// snn_config_loader
//   Receives a framed byte stream (SYNC, N_DATA data bytes, checksum) and
//   builds a shadow configuration image. When the modulo-256 sum of the data
//   bytes matches the checksum byte, the whole image is copied in one cycle
//   into the active registers that drive the network, so the network never
//   observes a partially written configuration.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   in_data/in_valid     byte stream input
//   in_ready             loader accepts a byte this cycle
//   abort                synchronous frame abort (drops the frame in progress)
//   weights, delays      active packed weight / delay buses
//   threshold, decay,
//   refractory_period    active neuron parameters
//   busy                 a frame is in progress
//   commit_pulse         one-cycle strobe on a successful commit
//   cfg_loaded           sticky, set on the first successful commit
//   crc_error            sticky, set on checksum mismatch, cleared by next SYNC
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is low only during the one-cycle CHECK state or while abort is high.
module snn_config_loader
    import snn_cfg_pkg::*;
#(
    parameter int         W_BITS    = 640,
    parameter int         D_BITS    = 320,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic [W_BITS-1:0] weights,
    output logic [D_BITS-1:0] delays,
    output logic [7:0]        threshold,
    output logic [7:0]        decay,
    output logic [7:0]        refractory_period,
    output logic              busy,
    output logic              commit_pulse,
    output logic              cfg_loaded,
    output logic              crc_error
);

    localparam int N_DATA   = (W_BITS + D_BITS) / 8 + 3;
    localparam int IMG_BITS = N_DATA * 8;
    localparam int CNT_W    = $clog2(N_DATA);

    // The package offsets describe the default geometry; when the buses are
    // resized, every field after the weights shifts by the size difference.
    localparam int SHIFT_W   = (W_BITS - W_BITS_DEFAULT) / 8;
    localparam int SHIFT_WD  = (W_BITS + D_BITS - W_BITS_DEFAULT - D_BITS_DEFAULT) / 8;
    localparam int W_BIT_OFF = WEIGHTS_OFF * 8;
    localparam int D_BIT_OFF = (DELAYS_OFF + SHIFT_W) * 8;
    localparam int T_BIT_OFF = (THR_OFF + SHIFT_WD) * 8;
    localparam int C_BIT_OFF = (DECAY_OFF + SHIFT_WD) * 8;
    localparam int R_BIT_OFF = (REFR_OFF + SHIFT_WD) * 8;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DATA - 1);

    cfg_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          sum_q;
    logic [7:0]          csum_q;
    logic [IMG_BITS-1:0] shadow_q;

    logic accept;
    logic sum_match;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q != CHECK) && !abort;
        accept    = in_valid && in_ready;
        sum_match = (csum_q == sum_q);

        unique case (state_q)
            IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) state_d = LOAD;
            end
            LOAD: begin
                // SYNC values inside the frame are plain data: no resync.
                if (abort)                               state_d = IDLE;
                else if (accept && (cnt_q == LAST_CNT))  state_d = CSUM;
            end
            CSUM: begin
                if (abort)       state_d = IDLE;
                else if (accept) state_d = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Datapath: shadow image, running sum, active registers, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q             <= '0;
            sum_q             <= '0;
            csum_q            <= '0;
            shadow_q          <= '0;
            weights           <= '0;
            delays            <= '0;
            threshold         <= '0;
            decay             <= '0;
            refractory_period <= '0;
            commit_pulse      <= 1'b0;
            cfg_loaded        <= 1'b0;
            crc_error         <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        cnt_q     <= '0;
                        sum_q     <= '0;
                        crc_error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow_q[{cnt_q, 3'b000} +: 8] <= in_data;
                        sum_q <= sum_q + in_data;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CSUM: begin
                    if (accept) csum_q <= in_data;
                end
                CHECK: begin
                    // Abort wins over the commit decision.
                    if (!abort) begin
                        if (sum_match) begin
                            weights           <= shadow_q[W_BIT_OFF +: W_BITS];
                            delays            <= shadow_q[D_BIT_OFF +: D_BITS];
                            threshold         <= shadow_q[T_BIT_OFF +: 8];
                            decay             <= shadow_q[C_BIT_OFF +: 8];
                            refractory_period <= shadow_q[R_BIT_OFF +: 8];
                            commit_pulse      <= 1'b1;
                            cfg_loaded        <= 1'b1;
                        end else begin
                            crc_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_config_loader.sv
// tb_snn_config_loader
//   Directed bench for snn_config_loader with hand-computed checksums.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, away from the rising edge where the DUT updates.
module tb_snn_config_loader;

    localparam int W_BITS = 640;
    localparam int D_BITS = 320;
    localparam int N_DATA = 123;

    logic              clk;
    logic              reset_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic [W_BITS-1:0] weights;
    logic [D_BITS-1:0] delays;
    logic [7:0]        threshold;
    logic [7:0]        decay;
    logic [7:0]        refractory_period;
    logic              busy;
    logic              commit_pulse;
    logic              cfg_loaded;
    logic              crc_error;

    snn_config_loader #(
        .W_BITS   (W_BITS),
        .D_BITS   (D_BITS),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .abort            (abort),
        .weights          (weights),
        .delays           (delays),
        .threshold        (threshold),
        .decay            (decay),
        .refractory_period(refractory_period),
        .busy             (busy),
        .commit_pulse     (commit_pulse),
        .cfg_loaded       (cfg_loaded),
        .crc_error        (crc_error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- frame model ----------------
    logic [7:0]        fb [N_DATA];
    logic [W_BITS-1:0] exp_w;
    logic [D_BITS-1:0] exp_d;

    task automatic build_frame(input logic [7:0] thr, input logic [7:0] dcy, input logic [7:0] refr);
        for (int k = 0; k < 80; k++) begin
            fb[k] = 8'(k);
            exp_w[k*8 +: 8] = 8'(k);
        end
        for (int k = 80; k < 120; k++) begin
            fb[k] = 8'h3C;
            exp_d[(k-80)*8 +: 8] = 8'h3C;
        end
        fb[120] = thr;
        fb[121] = dcy;
        fb[122] = refr;
    endtask

    // ---------------- drivers ----------------
    // Entered and left just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 8) begin
            in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("ready_wait", 640'(in_ready), 640'(1));
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic gap();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_data(input int first, input int count, input bit toggle);
        for (int k = first; k < first + count; k++) begin
            send_byte(fb[k]);
            if (toggle) gap();
        end
    endtask

    // Returns one falling edge after the checksum handshake (DUT in CHECK).
    task automatic send_frame(input logic [7:0] csum, input bit toggle);
        send_byte(8'hA5);
        if (toggle) gap();
        send_data(0, N_DATA, toggle);
        send_byte(csum);
        in_valid = 1'b0;
    endtask

    task automatic check_active(input string tag, input logic [7:0] thr,
                                input logic [7:0] dcy, input logic [7:0] refr);
        check_eq({tag, "_weights"}, 640'(weights), 640'(exp_w));
        check_eq({tag, "_delays"},  640'(delays),  640'(exp_d));
        check_eq({tag, "_thr"},     640'(threshold), 640'(thr));
        check_eq({tag, "_decay"},   640'(decay), 640'(dcy));
        check_eq({tag, "_refr"},    640'(refractory_period), 640'(refr));
    endtask

    // ---------------- stimulus ----------------
    int t0;

    initial begin
        reset_n  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        abort    = 1'b0;
        exp_w    = '0;
        exp_d    = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_active("rst", 8'h00, 8'h00, 8'h00);
        check_eq("rst_in_ready",   640'(in_ready), 640'(1));
        check_eq("rst_busy",       640'(busy), 640'(0));
        check_eq("rst_cfg_loaded", 640'(cfg_loaded), 640'(0));
        check_eq("rst_crc_error",  640'(crc_error), 640'(0));
        check_eq("rst_commit",     640'(commit_pulse), 640'(0));

        // Valid frame: sum = 0x58+0x60+0x40+0x02+0x05 = 0xFF
        build_frame(8'h40, 8'h02, 8'h05);
        t0 = cyc;
        send_frame(8'hFF, 1'b0);
        check_eq("v1_busy_in_check",  640'(busy), 640'(1));
        check_eq("v1_ready_in_check", 640'(in_ready), 640'(0));
        check_eq("v1_commit_early",   640'(commit_pulse), 640'(0));
        check_eq("v1_thr_early",      640'(threshold), 640'(0));
        @(negedge clk);
        check_eq("v1_frame_cycles", 640'(cyc - t0), 640'(126));
        check_eq("v1_commit",     640'(commit_pulse), 640'(1));
        check_eq("v1_cfg_loaded", 640'(cfg_loaded), 640'(1));
        check_eq("v1_busy_after", 640'(busy), 640'(0));
        check_eq("v1_w_lo",       640'(weights[7:0]), 640'(8'h00));
        check_eq("v1_w_hi",       640'(weights[639:632]), 640'(8'h4F));
        check_eq("v1_d_lo",       640'(delays[7:0]), 640'(8'h3C));
        check_active("v1", 8'h40, 8'h02, 8'h05);
        @(negedge clk);
        check_eq("v1_commit_one_cycle", 640'(commit_pulse), 640'(0));

        // Checksum off by one: threshold 0x41 gives sum 0x00, 0xFF is sent
        build_frame(8'h41, 8'h02, 8'h05);
        send_frame(8'hFF, 1'b0);
        check_eq("bad_commit_check", 640'(commit_pulse), 640'(0));
        @(negedge clk);
        check_eq("bad_commit",     640'(commit_pulse), 640'(0));
        check_eq("bad_crc_error",  640'(crc_error), 640'(1));
        check_eq("bad_cfg_loaded", 640'(cfg_loaded), 640'(1));
        check_eq("bad_thr_kept",   640'(threshold), 640'(8'h40));
        check_eq("bad_refr_kept",  640'(refractory_period), 640'(8'h05));

        // Junk before SYNC, in_valid toggling; decay 0x03 gives sum 0x00
        build_frame(8'h40, 8'h03, 8'h05);
        send_byte(8'h00);
        send_byte(8'h13);
        in_valid = 1'b0;
        check_eq("junk_busy", 640'(busy), 640'(0));
        check_eq("junk_crc_kept", 640'(crc_error), 640'(1));
        t0 = cyc;
        send_byte(8'hA5);
        gap();
        check_eq("tog_sync_busy", 640'(busy), 640'(1));
        check_eq("tog_crc_cleared", 640'(crc_error), 640'(0));
        send_data(0, N_DATA, 1'b1);
        send_byte(8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("tog_frame_cycles", 640'(cyc - t0), 640'(250));
        check_eq("tog_commit", 640'(commit_pulse), 640'(1));
        check_active("tog", 8'h40, 8'h03, 8'h05);

        // Abort after 50 data bytes, with a byte offered at the same time
        build_frame(8'h40, 8'h02, 8'h07);
        send_byte(8'hA5);
        send_data(0, 50, 1'b0);
        abort    = 1'b1;
        in_data  = 8'h11;
        in_valid = 1'b1;
        #1;
        check_eq("abort_ready_low", 640'(in_ready), 640'(0));
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("abort_busy",   640'(busy), 640'(0));
        check_eq("abort_commit", 640'(commit_pulse), 640'(0));
        check_eq("abort_decay",  640'(decay), 640'(8'h03));
        // Following full frame: sum = 0xFF + 2 = 0x01
        send_frame(8'h01, 1'b0);
        @(negedge clk);
        check_eq("post_abort_commit", 640'(commit_pulse), 640'(1));
        check_active("post_abort", 8'h40, 8'h02, 8'h07);

        // Abort during CHECK suppresses a valid commit (thr 0x55 -> sum 0x14)
        build_frame(8'h55, 8'h02, 8'h05);
        send_frame(8'h14, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("chk_abort_commit", 640'(commit_pulse), 640'(0));
        check_eq("chk_abort_thr",    640'(threshold), 640'(8'h40));
        check_eq("chk_abort_crc",    640'(crc_error), 640'(0));
        check_eq("chk_abort_busy",   640'(busy), 640'(0));

        // Reset 20 bytes into a frame clears everything asynchronously
        build_frame(8'h40, 8'h02, 8'h05);
        send_byte(8'hA5);
        send_data(0, 20, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        exp_w = '0;
        exp_d = '0;
        check_active("async_rst", 8'h00, 8'h00, 8'h00);
        check_eq("async_rst_busy",       640'(busy), 640'(0));
        check_eq("async_rst_cfg_loaded", 640'(cfg_loaded), 640'(0));
        check_eq("async_rst_in_ready",   640'(in_ready), 640'(1));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        build_frame(8'h40, 8'h02, 8'h05);
        send_frame(8'hFF, 1'b0);
        @(negedge clk);
        check_eq("fresh_commit",     640'(commit_pulse), 640'(1));
        check_eq("fresh_cfg_loaded", 640'(cfg_loaded), 640'(1));
        check_active("fresh", 8'h40, 8'h02, 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
